// File: rtl/peripheral_dbg_jsp_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel JTAG serial port.
package peripheral_dbg_jsp_pkg;

  typedef enum logic [2:0] {
    REG_DATA  = 3'd0,
    REG_IER   = 3'd1,
    REG_IIR   = 3'd2,
    REG_LSR   = 3'd3,
    REG_RXCNT = 3'd4,
    REG_TXCNT = 3'd5
  } reg_e;

  localparam int IER_RX    = 0;
  localparam int IER_TX    = 1;
  localparam int IIR_RX    = 0;
  localparam int IIR_TX    = 1;
  localparam int LSR_RX_NE = 0;
  localparam int LSR_OVF   = 1;
  localparam int LSR_TX_NF = 5;
  localparam int LSR_TX_E  = 6;

  localparam int CNT_SAT = 255;

  function automatic logic [7:0] sat_cnt(input int unsigned cnt);
    logic [31:0] c;
    c = cnt;
    return (cnt > CNT_SAT) ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/peripheral_dbg_jsp_fifo.sv
// 8-bit synchronous FIFO with occupancy count; a full FIFO accepts push when popped the same cycle.
module peripheral_dbg_jsp_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/peripheral_dbg_jsp_mc_wb.sv
// Multi-channel JSP Wishbone target: per-channel RX/TX FIFOs, 16550-style registers, shared interrupt.
module peripheral_dbg_jsp_mc_wb
  import peripheral_dbg_jsp_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ADR_WIDTH  = $clog2(CHANNELS) + 3,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 wb_jsp_clk_i,
  input  logic                 wb_jsp_rst_i,
  input  logic                 wb_jsp_cyc_i,
  input  logic                 wb_jsp_stb_i,
  input  logic                 wb_jsp_we_i,
  input  logic [ADR_WIDTH-1:0] wb_jsp_adr_i,
  input  logic [7:0]           wb_jsp_dat_i,
  output logic [7:0]           wb_jsp_dat_o,
  output logic                 wb_jsp_ack_o,
  output logic                 wb_jsp_err_o,
  output logic                 jsp_int_o,
  input  logic                 dbg_rx_valid_i,
  input  logic [CW-1:0]        dbg_rx_chan_i,
  input  logic [7:0]           dbg_rx_data_i,
  output logic                 dbg_rx_ready_o,
  input  logic [CW-1:0]        dbg_tx_chan_i,
  output logic                 dbg_tx_valid_o,
  output logic [7:0]           dbg_tx_data_o,
  input  logic                 dbg_tx_ready_i
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic [CHANNELS-1:0] rx_push, rx_pop, rx_full, rx_empty;
  logic [CHANNELS-1:0] tx_push, tx_pop, tx_full, tx_empty;
  logic [CHANNELS-1:0] chan_irq;
  logic [CHANNELS-1:0] ovf;
  logic [7:0]          rx_dout  [CHANNELS];
  logic [7:0]          tx_dout  [CHANNELS];
  logic [CNTW-1:0]     rx_count [CHANNELS];
  logic [CNTW-1:0]     tx_count [CHANNELS];
  logic [1:0]          ier      [CHANNELS];

  logic        ack_q, err_q, int_q;
  logic [7:0]  dat_q;
  logic [7:0]  rd_data;
  logic        access, chan_ok, reg_ok, hit, bad;
  int unsigned chan_num;
  logic [CW-1:0] chan_sel;
  logic [2:0]  reg_off;
  reg_e        reg_sel;
  logic        rx_chan_ok, tx_chan_ok;

  // The ack/err cycle blocks a new access, giving at most one access per two cycles.
  assign access   = wb_jsp_cyc_i & wb_jsp_stb_i & ~ack_q & ~err_q;
  assign reg_off  = wb_jsp_adr_i[2:0];
  assign reg_sel  = reg_e'(reg_off);
  assign chan_num = 32'(wb_jsp_adr_i >> 3);
  assign chan_sel = CW'(chan_num);
  assign chan_ok  = (chan_num < CHANNELS);
  assign reg_ok   = (reg_off <= 3'd5);
  assign hit      = access & chan_ok & reg_ok;
  assign bad      = access & ~(chan_ok & reg_ok);

  assign rx_chan_ok = (32'(dbg_rx_chan_i) < CHANNELS);
  assign tx_chan_ok = (32'(dbg_tx_chan_i) < CHANNELS);

  always_comb begin
    rx_push = '0;
    rx_pop  = '0;
    tx_push = '0;
    tx_pop  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rx_push[c] = dbg_rx_valid_i & (32'(dbg_rx_chan_i) == c);
      tx_pop[c]  = dbg_tx_ready_i & (32'(dbg_tx_chan_i) == c);
      rx_pop[c]  = hit & ~wb_jsp_we_i & (reg_sel == REG_DATA) & (chan_num == c);
      tx_push[c] = hit &  wb_jsp_we_i & (reg_sel == REG_DATA) & (chan_num == c);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    peripheral_dbg_jsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (wb_jsp_clk_i),
      .rst   (wb_jsp_rst_i),
      .push  (rx_push[c]),
      .pop   (rx_pop[c]),
      .din   (dbg_rx_data_i),
      .dout  (rx_dout[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c]),
      .count (rx_count[c])
    );

    peripheral_dbg_jsp_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (wb_jsp_clk_i),
      .rst   (wb_jsp_rst_i),
      .push  (tx_push[c]),
      .pop   (tx_pop[c]),
      .din   (wb_jsp_dat_i),
      .dout  (tx_dout[c]),
      .full  (tx_full[c]),
      .empty (tx_empty[c]),
      .count (tx_count[c])
    );

    assign chan_irq[c] = (ier[c][IER_RX] & ~rx_empty[c]) | (ier[c][IER_TX] & tx_empty[c]);
  end

  always_comb begin
    rd_data = '0;
    if (chan_ok) begin
      case (reg_sel)
        REG_DATA:  rd_data = rx_empty[chan_sel] ? 8'h00 : rx_dout[chan_sel];
        REG_IER:   rd_data = {6'b0, ier[chan_sel]};
        REG_IIR: begin
          rd_data[IIR_RX] = ier[chan_sel][IER_RX] & ~rx_empty[chan_sel];
          rd_data[IIR_TX] = ier[chan_sel][IER_TX] & tx_empty[chan_sel];
        end
        REG_LSR: begin
          rd_data[LSR_RX_NE] = ~rx_empty[chan_sel];
          rd_data[LSR_OVF]   = ovf[chan_sel];
          rd_data[LSR_TX_NF] = ~tx_full[chan_sel];
          rd_data[LSR_TX_E]  = tx_empty[chan_sel];
        end
        REG_RXCNT: rd_data = sat_cnt(32'(rx_count[chan_sel]));
        REG_TXCNT: rd_data = sat_cnt(32'(tx_count[chan_sel]));
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge wb_jsp_clk_i or posedge wb_jsp_rst_i) begin
    if (wb_jsp_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      int_q <= 1'b0;
      ovf   <= '0;
      for (int c = 0; c < CHANNELS; c++) ier[c] <= '0;
    end else begin
      ack_q <= hit;
      err_q <= bad;
      int_q <= |chan_irq;
      if (access) dat_q <= (hit & ~wb_jsp_we_i) ? rd_data : 8'h00;
      for (int c = 0; c < CHANNELS; c++) begin
        // A byte is lost only if the debug side is not draining in the same cycle.
        if (tx_push[c] & tx_full[c] & ~tx_pop[c])
          ovf[c] <= 1'b1;
        else if (hit & ~wb_jsp_we_i & (reg_sel == REG_LSR) & (chan_num == c))
          ovf[c] <= 1'b0;
        if (hit & wb_jsp_we_i & (reg_sel == REG_IER) & (chan_num == c))
          ier[c] <= wb_jsp_dat_i[1:0];
      end
    end
  end

  assign wb_jsp_ack_o = ack_q;
  assign wb_jsp_err_o = err_q;
  assign wb_jsp_dat_o = dat_q;
  assign jsp_int_o    = int_q;

  assign dbg_rx_ready_o = rx_chan_ok & ~rx_full[dbg_rx_chan_i];
  assign dbg_tx_valid_o = tx_chan_ok & ~tx_empty[dbg_tx_chan_i];
  assign dbg_tx_data_o  = dbg_tx_valid_o ? tx_dout[dbg_tx_chan_i] : 8'h00;

endmodule
